// File: rtl/byteram_port.sv
// Byte-lane-masked, word-addressed RAM port with valid/ready requests, a fixed-latency
// response pipeline and a self-clearing initialisation pass after every reset.
module byteram_port #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          WRITE_FIRST  = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_byteena,
    input  logic                    req_wren,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic                    init_done
);

    localparam int unsigned NumLanes = DATA_WIDTH / 8;
    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough that neither the address nor DEPTH is truncated in the range check.
    localparam int unsigned CmpWidth = (ADDR_WIDTH > 32) ? ADDR_WIDTH + 1 : 33;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                state_q, state_d;
    logic [IdxWidth-1:0]   clr_cnt_q, clr_cnt_d;
    logic                  clr_we;
    logic                  clr_last;

    logic                  accept;
    logic                  in_range;
    logic [IdxWidth-1:0]   idx;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged_word;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] resp_word;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [READ_LATENCY-1:0] pipe_valid_q;
    logic [READ_LATENCY-1:0] pipe_err_q;
    logic [DATA_WIDTH-1:0]   pipe_data_q [READ_LATENCY];

    assign clr_last = (clr_cnt_q == IdxWidth'(DEPTH - 1));

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StInit;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StInit: begin
                if (clr_last) begin
                    state_d   = StRun;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + IdxWidth'(1);
                end
            end
            StRun: begin
                state_d = StRun;
            end
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        req_ready = 1'b0;
        init_done = 1'b0;
        clr_we    = 1'b0;
        unique case (state_q)
            StInit: clr_we = 1'b1;
            StRun: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------- request datapath
    assign accept   = req_valid & req_ready;
    assign in_range = CmpWidth'(req_addr) < CmpWidth'(DEPTH);
    assign idx      = req_addr[IdxWidth-1:0];
    assign old_word = mem_q[idx];

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NumLanes; i++) begin
            lane_mask[8*i +: 8] = {8{req_byteena[i]}};
        end
    end

    assign merged_word = (old_word & ~lane_mask) | (req_wdata & lane_mask);

    always_comb begin
        resp_word = '0;
        if (in_range) begin
            if (WRITE_FIRST && req_wren) begin
                resp_word = merged_word & lane_mask;
            end else begin
                resp_word = old_word & lane_mask;
            end
        end
    end

    // Clearing has priority; requests cannot be accepted during INIT anyway.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (accept && req_wren && in_range) begin
            mem_q[idx] <= merged_word;
        end
    end

    // ---------------------------------------------------------------- response pipeline
    // Data/err advance only with a valid entry so the output stage holds between pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                pipe_data_q[k] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= accept;
            if (accept) begin
                pipe_data_q[0] <= resp_word;
                pipe_err_q[0]  <= ~in_range;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid_q[k] <= pipe_valid_q[k-1];
                if (pipe_valid_q[k-1]) begin
                    pipe_data_q[k] <= pipe_data_q[k-1];
                    pipe_err_q[k]  <= pipe_err_q[k-1];
                end
            end
        end
    end

    assign resp_valid = pipe_valid_q[READ_LATENCY-1];
    assign resp_rdata = pipe_data_q[READ_LATENCY-1];
    assign resp_err   = pipe_err_q[READ_LATENCY-1];

endmodule
